// File: rtl/seg7_scan_if.sv
// Digit/control inputs and multiplexed segment outputs of the 4-digit scanner.
interface seg7_scan_if;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [3:0] blink;
    logic       lz_blank;
    logic       dp_en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output dig0, dig1, dig2, dig3, blink, lz_blank, dp_en,
        input  seg, an, dp
    );

    modport slave (
        input  dig0, dig1, dig2, dig3, blink, lz_blank, dp_en,
        output seg, an, dp
    );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed 4-digit seven-segment driver with frame-coherent sampling,
// per-digit blink, leading-zero blanking and a min:sec separator dot.
module seg7_scan #(
    parameter int unsigned SCAN_DIV    = 12500,
    parameter int unsigned BLINK_TICKS = 1000
) (
    input logic        clk,
    input logic        rst,
    seg7_scan_if.slave bus
);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    typedef enum logic [1:0] {S_OFF, S_DEAD, S_SHOW} state_t;

    state_t      state, state_n;
    logic [PW-1:0] pcnt;
    logic [BW-1:0] bcnt;
    logic        tick;
    logic [1:0]  idx;
    logic [1:0]  sel;
    logic [15:0] latch;
    logic        phase;
    logic [3:0]  val;
    logic        blank;
    logic [6:0]  seg_q, seg_n;
    logic [3:0]  an_q, an_n;
    logic        dp_q, dp_n;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign tick = (pcnt == PW'(SCAN_DIV - 1));

    // sel remembers which digit the tick chose, for display after the dead cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt  <= '0;
            idx   <= '0;
            sel   <= '0;
            bcnt  <= '0;
            phase <= 1'b0;
            latch <= '0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= idx + 1'b1;
                sel <= idx;
                if (idx == 2'd0)
                    latch <= {bus.dig3, bus.dig2, bus.dig1, bus.dig0};
                if (bcnt == BW'(BLINK_TICKS - 1)) begin
                    bcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_OFF;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (tick)
            state_n = S_DEAD;
        else if (state == S_DEAD)
            state_n = S_SHOW;
    end

    always_comb begin
        case (sel)
            2'd0:    val = latch[3:0];
            2'd1:    val = latch[7:4];
            2'd2:    val = latch[11:8];
            default: val = latch[15:12];
        endcase
        blank = (val > 4'd9) | (bus.blink[sel] & phase)
              | (bus.lz_blank & (sel == 2'd3) & (val == 4'd0));
    end

    // Pattern is captured once on entering SHOW and held for the rest of the slot
    always_comb begin
        seg_n = seg_q;
        an_n  = an_q;
        dp_n  = dp_q;
        if (state_n != S_SHOW) begin
            seg_n = '1;
            an_n  = '1;
            dp_n  = 1'b1;
        end else if (state == S_DEAD) begin
            an_n  = ~(4'b0001 << sel);
            seg_n = blank ? 7'b1111111 : decode(val);
            dp_n  = ~(bus.dp_en & (sel == 2'd2));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_q <= '1;
            an_q  <= '1;
            dp_q  <= 1'b1;
        end else begin
            seg_q <= seg_n;
            an_q  <= an_n;
            dp_q  <= dp_n;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;
    assign bus.dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// Directed scoreboard bench for seg7_scan with SCAN_DIV=4, BLINK_TICKS=8.
module tb_seg7_scan;
    localparam int unsigned SD = 4;
    localparam logic [11:0] OFF = 12'hFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   frame_no = 0;
    logic [11:0] sbq[$];

    seg7_scan_if bus ();

    seg7_scan #(.SCAN_DIV(SD), .BLINK_TICKS(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat(input logic [3:0] v);
        case (v)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
    endfunction

    function automatic logic [11:0] outs();
        return {bus.an, bus.seg, bus.dp};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed an/seg/dp=%b expected %b", tag, obs, exp);
        end
    endtask

    // Phase seen by digit i of frame f: toggles at the last tick of every second frame
    task automatic push_digit(input int unsigned i, input logic [3:0] v);
        logic       ph;
        logic       blk;
        logic [3:0] an;
        logic       dpx;
        ph  = (i == 3) ? (((frame_no + 1) >> 1) & 1) != 0 : ((frame_no >> 1) & 1) != 0;
        blk = (v > 4'd9) || (bus.blink[i] && ph) || (bus.lz_blank && i == 3 && v == 4'd0);
        an  = ~(4'b0001 << i);
        dpx = !(i == 2 && bus.dp_en);
        sbq.push_back({an, blk ? 7'b1111111 : pat(v), dpx});
    endtask

    task automatic wait_start(input string tag);
        logic [11:0] exp;
        int unsigned n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.an === 4'hF && n < 3 * SD);
        exp = sbq.pop_front();
        chk(tag, outs(), exp);
    endtask

    task automatic wait_end(input string tag);
        logic [3:0]  cur;
        int unsigned n;
        cur = bus.an;
        n = 1;
        for (int unsigned k = 0; k < 2 * SD; k++) begin
            @(negedge clk);
            if (bus.an !== cur) break;
            n++;
        end
        chk({tag, "_len"}, 12'(n), 12'(SD - 1));
        chk({tag, "_dead"}, outs(), OFF);
    endtask

    task automatic run_frame(input logic [3:0] v0, v1, v2, v3,
                             input bit mid_en, input logic [3:0] m0, m1, m2, m3);
        push_digit(0, v0);
        push_digit(1, v1);
        push_digit(2, v2);
        push_digit(3, v3);
        for (int unsigned i = 0; i < 4; i++) begin
            wait_start($sformatf("f%0d_d%0d", frame_no, i));
            if (i == 2 && mid_en) begin
                bus.dig0 = m0;
                bus.dig1 = m1;
                bus.dig2 = m2;
                bus.dig3 = m3;
            end
            wait_end($sformatf("f%0d_d%0d", frame_no, i));
        end
        frame_no++;
    endtask

    task automatic release_check(input string tag);
        rst = 1'b1;
        for (int unsigned c = 0; c < SD; c++) begin
            @(negedge clk);
            chk($sformatf("%s_off%0d", tag, c), outs(), OFF);
        end
        frame_no = 0;
    endtask

    initial begin
        bus.dig0 = 4'd5;
        bus.dig1 = 4'd9;
        bus.dig2 = 4'd0;
        bus.dig3 = 4'd1;
        bus.blink = 4'b0000;
        bus.lz_blank = 1'b0;
        bus.dp_en = 1'b1;

        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("reset%0d", c), outs(), OFF);
        end
        release_check("rel");

        run_frame(5, 9, 0, 1, 0, 0, 0, 0, 0);
        // dig1 and dig3 change mid-frame; current frame must still show 9/1
        run_frame(5, 9, 0, 1, 1, 5, 3, 0, 2);
        bus.blink = 4'b0001;
        run_frame(5, 3, 0, 2, 0, 0, 0, 0, 0);
        run_frame(5, 3, 0, 2, 0, 0, 0, 0, 0);
        run_frame(5, 3, 0, 2, 0, 0, 0, 0, 0);
        run_frame(5, 3, 0, 2, 0, 0, 0, 0, 0);
        run_frame(5, 3, 0, 2, 0, 0, 0, 0, 0);
        bus.blink = 4'b0000;
        run_frame(5, 3, 0, 2, 1, 5, 3, 4'hA, 0);
        bus.lz_blank = 1'b1;
        run_frame(5, 3, 4'hA, 0, 0, 0, 0, 0, 0);
        bus.lz_blank = 1'b0;
        bus.dp_en = 1'b0;
        run_frame(5, 3, 4'hA, 0, 1, 8, 3, 7, 0);
        run_frame(8, 3, 7, 0, 0, 0, 0, 0, 0);

        push_digit(0, 4'd8);
        push_digit(1, 4'd3);
        push_digit(2, 4'd7);
        for (int unsigned i = 0; i < 2; i++) begin
            wait_start($sformatf("mid_d%0d", i));
            wait_end($sformatf("mid_d%0d", i));
        end
        wait_start("mid_d2");
        rst = 1'b0;
        bus.dig0 = 4'd2;
        bus.dig1 = 4'd4;
        bus.dig2 = 4'd6;
        bus.dig3 = 4'd9;
        bus.dp_en = 1'b1;
        @(negedge clk);
        chk("mid_reset", outs(), OFF);
        release_check("mid_rel");
        run_frame(2, 4, 6, 9, 0, 0, 0, 0, 0);
        run_frame(2, 4, 6, 9, 0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed 4-digit seven-segment driver consuming the four BCD digits produced by the minute/second counters (sec lower, sec upper, min lower, min upper). It serves boards with a shared segment bus and per-digit common-anode selects, as an alternative to four static per-digit decoders. Adds frame-coherent digit sampling, per-digit blink for time-setting feedback, leading-zero blanking and a min:sec separator dot.

## Interface
- SCAN_DIV, 12500: clocks per scan tick; one digit is shown per tick. Must be ≥ 2.
- BLINK_TICKS, 1000: scan ticks per blink-phase toggle.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- dig0  in  4  BCD, seconds lower.
- dig1  in  4  BCD, seconds upper.
- dig2  in  4  BCD, minutes lower.
- dig3  in  4  BCD, minutes upper.
- blink  in  4  per-digit blink mask; bit i = digit i.
- lz_blank  in  1  blank digit 3 when its value is 0.
- dp_en  in  1  light the decimal point on digit 2 as the min:sec separator.
- seg  out  7  segments, active-low; seg[0]=a … seg[6]=g.
- an  out  4  digit selects, active-low, at most one low.
- dp  out  1  decimal point, active-low.

## Operation
- Prescaler `pcnt`:
  - counts 0..SCAN_DIV-1 and wraps to 0.
  - `tick` is asserted in the cycle where pcnt == SCAN_DIV-1.
- Digit index `idx` (2 bit):
  - names the next digit to display.
  - On each tick: display `idx`, then idx ← idx+1, wrapping 3→0.
- Frame latch (16 bit):
  - on a tick where idx == 0, captures {dig3,dig2,dig1,dig0} before digit 0 is displayed.
  - All four digits of a frame come from one sample. Input changes mid-frame are not visible until the next frame.
- Blink:
  - `bcnt` counts ticks 0..BLINK_TICKS-1.
  - `phase` toggles on the tick where bcnt == BLINK_TICKS-1.
  - While phase = 1, digit i is blanked if blink[i] = 1.
- Blank conditions for the displayed digit (any one blanks it: seg = 7'b1111111, `an` still selects the digit):
  - latched value > 9;
  - blink[i] & phase;
  - lz_blank & (i == 3) & (value == 0).
- Decode, active-low, bit order gfedcba:
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- dp:
  - 0 while digit 2 is displayed and dp_en = 1; otherwise 1.
  - dp is not affected by blink or blanking.
- blink, lz_blank and dp_en are sampled live, at display time, not frame-latched.

## Timing
- Reset (rst = 0 at a clk edge):
  - pcnt = 0, idx = 0, bcnt = 0, phase = 0, latch = 0.
  - Outputs: an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Outputs stay at these values until the first post-reset tick has been processed.
- Tick at cycle T:
  - T+1: dead cycle, with an = 1111, seg = 1111111, dp = 1 (anti-ghosting).
  - T+2: an selects digit idx(T), and seg/dp show its pattern.
  - The selection holds through the next tick cycle. Each digit is therefore valid for SCAN_DIV-1 cycles, then there is one dead cycle.
- First tick after reset release arrives SCAN_DIV cycles after the first cycle with rst = 1.
- Select patterns:
  - digit 0: an = 1110
  - digit 1: an = 1101
  - digit 2: an = 1011
  - digit 3: an = 0111
- A phase toggle on a tick applies to the digit displayed for that tick.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset mid-operation takes effect at the next clk edge regardless of pcnt or idx. The scan restarts at digit 0 with a fresh frame latch.

## Test plan
Bench parameters: SCAN_DIV = 4, BLINK_TICKS = 8.
- **Reset:** hold rst = 0 for 5 cycles, then release.
  - During reset: an = 1111, seg = 1111111, dp = 1.
  - In the 4th cycle after release, tick is asserted. The next cycle is dead. The cycle after that shows an = 1110.
- **Scan order:** dig0..3 = 5, 9, 0, 1; lz_blank = 0; dp_en = 1.
  - Sequence: an 1110/seg 0010010, 1101/0010000, 1011/1000000 with dp = 0, 0111/1111001, repeating.
  - Each digit is valid for 3 cycles, separated by 1 all-off cycle.
- **Frame coherence:** change dig1 from 9 to 3 while digit 2 is displayed.
  - The remainder of the current frame is unchanged.
  - Digit 1 shows 0110000 only in the next frame.
- **Blink:** blink = 0001.
  - Digit 0 shows seg = 1111111 (an = 1110 still asserted) for 2 consecutive frames, then shows its normal pattern for 2 frames, alternating.
  - Other digits are unaffected.
- **Blanking:** dig3 = 0 with lz_blank = 1 gives an = 0111, seg = 1111111. dig2 = 4'hA gives digit 2 blank.
  - With lz_blank = 0, digit 3 shows 1000000.
- **Reset mid-scan:** assert rst for 1 cycle while digit 2 is displayed.
  - The next cycle has the reset output values.
  - Scanning resumes at digit 0, SCAN_DIV cycles after release.
